// File: rtl/fwd_hazard_unit_v2.sv
// Decode-stage operand bypass (EXE/MEM/WB), load-use detection, HI/LO producer
// tracking for multi-cycle mult/div, and a saturating stall-cycle counter.
module fwd_hazard_unit_v2 #(
  parameter int DATA_W  = 32,
  parameter int AREG_W  = 5,
  parameter int NSRC    = 2,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     de_valid,
  input  logic [NSRC*AREG_W-1:0]   de_src_addr,
  input  logic [NSRC-1:0]          de_src_used,
  input  logic [NSRC*DATA_W-1:0]   de_src_rf,
  input  logic                     de_hilo_read,
  input  logic                     de_md_start,
  input  logic                     de_md_is_div,
  input  logic                     exe_valid,
  input  logic                     exe_wen,
  input  logic                     exe_memread,
  input  logic [AREG_W-1:0]        exe_waddr,
  input  logic [DATA_W-1:0]        exe_wdata,
  input  logic                     mem_valid,
  input  logic                     mem_wen,
  input  logic [AREG_W-1:0]        mem_waddr,
  input  logic [DATA_W-1:0]        mem_wdata,
  input  logic                     wb_valid,
  input  logic                     wb_wen,
  input  logic [AREG_W-1:0]        wb_waddr,
  input  logic [DATA_W-1:0]        wb_wdata,
  input  logic                     flush,
  output logic [NSRC*DATA_W-1:0]   src_data,
  output logic                     stall,
  output logic                     md_busy,
  output logic                     md_done,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int LAT_W   = ($clog2(MAX_LAT + 1) < 6) ? 6 : $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0] MUL_CNT = LAT_W'(MUL_LAT);
  localparam logic [LAT_W-1:0] DIV_CNT = LAT_W'(DIV_LAT);
  localparam logic [LAT_W-1:0] ONE_CNT = LAT_W'(1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  md_state_t        state, state_nxt;
  logic [LAT_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;
  logic             lu_hit;
  logic             md_haz;
  logic             accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Bypass select: each port looks only at its own address; youngest producer wins.
  always_comb begin
    src_data = de_src_rf;
    lu_hit   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (de_src_addr[i*AREG_W +: AREG_W] != '0) begin
        if (exe_valid && exe_wen && exe_waddr == de_src_addr[i*AREG_W +: AREG_W])
          src_data[i*DATA_W +: DATA_W] = exe_wdata;
        else if (mem_valid && mem_wen && mem_waddr == de_src_addr[i*AREG_W +: AREG_W])
          src_data[i*DATA_W +: DATA_W] = mem_wdata;
        else if (wb_valid && wb_wen && wb_waddr == de_src_addr[i*AREG_W +: AREG_W])
          src_data[i*DATA_W +: DATA_W] = wb_wdata;
        if (de_src_used[i] && exe_valid && exe_memread &&
            exe_waddr == de_src_addr[i*AREG_W +: AREG_W])
          lu_hit = 1'b1;
      end
    end
  end

  assign md_haz = de_valid & md_busy & (de_hilo_read | de_md_start);
  assign stall  = de_valid & ~flush & (lu_hit | md_haz);
  assign accept = de_valid & de_md_start & ~stall;

  // HI/LO tracker: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      md_done <= done_nxt;
    end
  end

  // HI/LO tracker: next state; flush wins over a same-cycle accept
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = de_md_is_div ? DIV_CNT : MUL_CNT;
        end
        BUSY: begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == ONE_CNT) state_nxt = IDLE;
        end
      endcase
    end
  end

  // HI/LO tracker: outputs; done is registered so it lands on the last busy cycle
  always_comb begin
    md_busy  = (state == BUSY);
    done_nxt = (state_nxt == BUSY) && (cnt_nxt == ONE_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst)        stall_cnt <= '0;
    else if (stall) stall_cnt <= sat_inc(stall_cnt);
  end

endmodule
